// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared encodings and constants for the fetch PC unit
package fetch_pc_unit_pkg;

   // Fetch sequencer states; encodings are fixed so waveforms read consistently
   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   // addi x0, x0, 0 -- decode substitutes this when flushing a fetched slot
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   // Instruction fetch is always word aligned; low two bits are dropped
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc_unit_pcplus4.sv
// rtl/fetch_pc_unit_pcplus4.sv - 32-bit modulo adder producing the sequential PC
module fetch_pc_unit_pcplus4 (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_y
);

   // Wraps silently at 2^32; no carry out is needed by the fetch path
   assign o_y = i_a + i_b;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter owner and single-outstanding instruction fetcher
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        misalign
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_req_pc;
   logic         r_kill;
   logic [31:0]  w_pc_plus4;
   logic [31:0]  w_redirect_aligned;

   fetch_pc_unit_pcplus4 u_pcplus4 (
      .i_a (r_pc),
      .i_b (PC_STEP),
      .o_y (w_pc_plus4)
   );

   assign w_redirect_aligned = word_align(redirect_pc);

   // Request channel is decoded from state so a new PC issues the cycle it is loaded
   assign imem_req_valid = (r_state == ST_REQ) && !rst;
   assign imem_req_addr  = r_pc;

   // Fetch sequencer: redirect overrides every state, a killed response is dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_REQ;
         r_pc     <= word_align(RESET_PC);
         r_req_pc <= word_align(RESET_PC);
         r_kill   <= 1'b0;
         if_valid <= 1'b0;
         if_pc    <= 32'h0000_0000;
         if_instr <= 32'h0000_0000;
         misalign <= 1'b0;
      end else begin
         misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         case (r_state)
            ST_REQ: begin
               if (imem_req_ready) begin
                  // The accepted request still returns a response; mark it dead if redirected
                  r_req_pc <= r_pc;
                  r_state  <= ST_WAIT;
                  if (redirect_valid) begin
                     r_pc   <= w_redirect_aligned;
                     r_kill <= 1'b1;
                  end else begin
                     r_pc   <= w_pc_plus4;
                  end
               end else if (redirect_valid) begin
                  r_pc <= w_redirect_aligned;
               end
            end
            ST_WAIT: begin
               if (redirect_valid) begin
                  r_pc <= w_redirect_aligned;
               end
               if (imem_rsp_valid) begin
                  if (r_kill || redirect_valid) begin
                     r_kill  <= 1'b0;
                     r_state <= ST_REQ;
                  end else begin
                     if_instr <= imem_rsp_data;
                     if_pc    <= r_req_pc;
                     if_valid <= 1'b1;
                     r_state  <= ST_HOLD;
                  end
               end else if (redirect_valid) begin
                  r_kill <= 1'b1;
               end
            end
            ST_HOLD: begin
               // A redirect withdraws the presented slot whether or not decode took it
               if (redirect_valid) begin
                  r_pc     <= w_redirect_aligned;
                  if_valid <= 1'b0;
                  r_state  <= ST_REQ;
               end else if (if_ready) begin
                  if_valid <= 1'b0;
                  r_state  <= ST_REQ;
               end
            end
            default: begin
               r_state  <= ST_REQ;
               if_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
